fetch_unit: RTL and testbench

Instruction fetch engine on the PC's consumer side: reads the PC value, issues a word read to instruction memory over a req/ack handshake, and captures the returned word into the instruction register. On acceptance it pulses `pc_enable` back to the program counter. It presents the instruction to the decoder over a valid/ready handshake and handles branch flushes from the control unit.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch engine.
//   fetch_state_t   - fetch FSM state encoding
//   *_DEFAULT       - default address/data widths and request timeout
package fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 16;
  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN,
    REDIR,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus.
//   mem_addr   - read address (fetch -> memory)
//   mem_rd_req - read request (fetch -> memory)
//   mem_rd_ack - read acknowledge, qualifies mem_rdata (memory -> fetch)
//   mem_rdata  - read data (memory -> fetch)
// Modports: master = fetch engine, slave = instruction memory.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd_req,
    input  mem_rd_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_req,
    output mem_rd_ack,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch engine.
// Reads pc_in, issues a word read over the memory req/ack bus, captures the
// returned word into the instruction register and presents it to the
// decoder over ir_valid/ir_ready. Branch flushes discard in-flight data and
// restart fetching from the redirected PC.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   run          - level, allows new fetches
//   pc_in        - current program counter
//   pc_enable    - combinational PC advance strobe (ack accepted in REQ)
//   flush        - one-cycle redirect pulse from the control unit
//   mem          - instruction memory read bus (fetch_unit_if.master)
//   ir_out       - instruction register
//   ir_valid     - ir_out holds an unconsumed instruction
//   ir_ready     - decoder accepts ir_out
//   fetch_err    - sticky request timeout error
// Build option: define FETCH_TIMEOUT_EN to enable the request timeout
// counter and the ERR state; otherwise fetch_err is tied low.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_enable,
  input  logic              flush,
  fetch_unit_if.master      mem,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  fetch_state_t state;
  logic         waiting;
  logic         wait_expired;

  // A request is outstanding in REQ and in DRAIN (flushed but not yet acked).
  assign waiting = (state == REQ) || (state == DRAIN);

  // The PC advances only when a non-flushed ack is accepted in REQ.
  assign pc_enable = (state == REQ) && mem.mem_rd_ack && !flush;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Counts completed wait cycles of the current request; zero outside
  // REQ/DRAIN so every entry into REQ starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (waiting && !mem.mem_rd_ack) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign wait_expired = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_err <= 1'b0;
    end else if (waiting && !mem.mem_rd_ack && wait_expired) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign fetch_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      mem.mem_addr   <= '0;
      mem.mem_rd_req <= 1'b0;
      ir_out         <= '0;
      ir_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state          <= REQ;
            mem.mem_addr   <= pc_in;
            mem.mem_rd_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem.mem_rd_ack) begin
            mem.mem_rd_req <= 1'b0;
            if (flush) begin
              state <= REDIR;
            end else begin
              state    <= HOLD;
              ir_out   <= mem.mem_rdata;
              ir_valid <= 1'b1;
            end
          end else if (wait_expired) begin
            mem.mem_rd_req <= 1'b0;
            state          <= ERR;
          end else if (flush) begin
            // Request stays asserted; the ack is awaited and discarded.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem.mem_rd_ack) begin
            mem.mem_rd_req <= 1'b0;
            state          <= REDIR;
          end else if (wait_expired) begin
            mem.mem_rd_req <= 1'b0;
            state          <= ERR;
          end
        end
        REDIR: begin
          state          <= REQ;
          mem.mem_addr   <= pc_in;
          mem.mem_rd_req <= 1'b1;
        end
        HOLD: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= REDIR;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            if (run) begin
              state          <= REQ;
              mem.mem_addr   <= pc_in;
              mem.mem_rd_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Stimulus pushes expected request addresses and accepted instructions into
// queues; a monitor pops and compares on each new request and each
// ir_valid/ir_ready handshake. Memory returns addr + 0x4000 on ack.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          run = 1'b0;
  logic          flush = 1'b0;
  logic          ir_ready = 1'b0;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] pc_init = 16'h0010;
  logic [AW-1:0] flush_pc = '0;
  logic          pc_enable;
  logic [DW-1:0] ir_out;
  logic          ir_valid;
  logic          fetch_err;

  int unsigned ack_delay = 0;
  bit          never_ack = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned pe_count = 0;
  int unsigned last_req_len = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_ir[$];

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .pc_in     (pc_in),
    .pc_enable (pc_enable),
    .flush     (flush),
    .mem       (mem_bus),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // Program counter model: loads on flush, increments on pc_enable.
  always @(posedge clk or negedge rst) begin
    if (!rst)           pc_in <= pc_init;
    else if (flush)     pc_in <= flush_pc;
    else if (pc_enable) pc_in <= pc_in + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: acks after ack_delay wait cycles of a request.
  initial begin
    int unsigned waited = 0;
    mem_bus.mem_rd_ack = 1'b0;
    mem_bus.mem_rdata  = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mem_bus.mem_rd_req === 1'b1) begin
        if (!never_ack && waited == ack_delay) begin
          mem_bus.mem_rd_ack = 1'b1;
          mem_bus.mem_rdata  = mem_bus.mem_addr + 16'h4000;
        end else begin
          mem_bus.mem_rd_ack = 1'b0;
          mem_bus.mem_rdata  = 16'hDEAD;
        end
        waited++;
      end else begin
        mem_bus.mem_rd_ack = 1'b0;
        mem_bus.mem_rdata  = 16'hDEAD;
        waited = 0;
      end
    end
  end

  // Monitor: samples mid-cycle, after inputs have settled.
  initial begin
    bit            req_prev = 1'b0;
    logic [AW-1:0] held = '0;
    int unsigned   cur_len = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1) begin
        req_prev = 1'b0;
      end else begin
        if (mem_bus.mem_rd_req && !req_prev) begin
          cur_len = 0;
          held = mem_bus.mem_addr;
          if (exp_addr.size() == 0) fail_event("unexpected_request");
          else check("req_addr", mem_bus.mem_addr, exp_addr.pop_front());
        end
        if (mem_bus.mem_rd_req) begin
          cur_len++;
          if (mem_bus.mem_addr !== held) begin
            fail_event("addr_stable");
          end
        end
        if (!mem_bus.mem_rd_req && req_prev) last_req_len = cur_len;
        req_prev = mem_bus.mem_rd_req;
        if (pc_enable) begin
          pe_count++;
          check("pe_qualified", {mem_bus.mem_rd_req, mem_bus.mem_rd_ack, flush}, 3'b110);
        end
        if (ir_valid && ir_ready) begin
          if (exp_ir.size() == 0) fail_event("unexpected_instruction");
          else check("ir_out", ir_out, exp_ir.pop_front());
        end
      end
    end
  end

  task automatic wait_pe(input int unsigned target);
    int unsigned n = 0;
    while (pe_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pe_count < target) fail_event("wait_pc_enable_timeout");
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (mem_bus.mem_rd_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (mem_bus.mem_rd_req !== 1'b1) fail_event("wait_req_timeout");
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (ir_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ir_valid !== 1'b1) fail_event("wait_ir_valid_timeout");
  endtask

  initial begin
    int unsigned base;
    rst = 1'b0;
    #3;
    check("rst_mem_addr", mem_bus.mem_addr, 16'h0000);
    check("rst_ir_out", ir_out, 16'h0000);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_mem_rd_req", mem_bus.mem_rd_req, 1'b0);
    check("rst_pc_enable", pc_enable, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Zero-wait memory, three back-to-back fetches from 0x0010.
    exp_addr.push_back(16'h0010); exp_addr.push_back(16'h0011); exp_addr.push_back(16'h0012);
    exp_ir.push_back(16'h4010);   exp_ir.push_back(16'h4011);   exp_ir.push_back(16'h4012);
    ack_delay = 0;
    ir_ready = 1'b1;
    run = 1'b1;
    wait_pe(3);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("zw_pe_count", pe_count, 3);
    check("zw_req_len", last_req_len, 1);
    check("zw_last_addr", mem_bus.mem_addr, 16'h0012);
    check("zw_idle_valid", ir_valid, 1'b0);

    // Ack delayed 3 cycles.
    @(negedge clk);
    base = pe_count;
    exp_addr.push_back(16'h0013);
    exp_ir.push_back(16'h4013);
    ack_delay = 3;
    run = 1'b1;
    wait_pe(base + 1);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("dly_req_len", last_req_len, 4);
    check("dly_pe_count", pe_count, base + 1);

    // Decoder stalls for 5 cycles in HOLD.
    @(negedge clk);
    exp_addr.push_back(16'h0014);
    exp_ir.push_back(16'h4014);
    ack_delay = 0;
    ir_ready = 1'b0;
    run = 1'b1;
    wait_valid();
    repeat (5) begin
      #3;
      check("stall_ir_valid", ir_valid, 1'b1);
      check("stall_ir_out", ir_out, 16'h4014);
      check("stall_no_req", mem_bus.mem_rd_req, 1'b0);
      @(negedge clk);
    end
    ir_ready = 1'b1;
    run = 1'b0;
    repeat (4) @(negedge clk);

    // Flush in the first cycle of a 3-cycle wait; redirect to 0x0200.
    base = pe_count;
    exp_addr.push_back(16'h0015); exp_addr.push_back(16'h0200);
    exp_ir.push_back(16'h4200);
    ack_delay = 3;
    run = 1'b1;
    wait_req();
    flush = 1'b1;
    flush_pc = 16'h0200;
    @(negedge clk);
    flush = 1'b0;
    wait_pe(base + 1);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("drain_pe_count", pe_count, base + 1);

    // Flush and ack in the same cycle; redirect to 0x0300.
    @(negedge clk);
    base = pe_count;
    exp_addr.push_back(16'h0201); exp_addr.push_back(16'h0300);
    exp_ir.push_back(16'h4300);
    ack_delay = 0;
    run = 1'b1;
    wait_req();
    flush = 1'b1;
    flush_pc = 16'h0300;
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("flush_ack_valid", ir_valid, 1'b0);
    check("flush_ack_redir_req", mem_bus.mem_rd_req, 1'b0);
    wait_pe(base + 1);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("flush_ack_pe_count", pe_count, base + 1);

    // Flush while holding an unconsumed instruction; redirect to 0x0400.
    @(negedge clk);
    base = pe_count;
    exp_addr.push_back(16'h0301); exp_addr.push_back(16'h0400);
    exp_ir.push_back(16'h4400);
    ir_ready = 1'b0;
    run = 1'b1;
    wait_valid();
    flush = 1'b1;
    flush_pc = 16'h0400;
    @(negedge clk);
    flush = 1'b0;
    ir_ready = 1'b1;
    #3;
    check("hold_flush_valid", ir_valid, 1'b0);
    wait_pe(base + 2);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("hold_flush_pe_count", pe_count, base + 2);

    // Reset in the middle of an outstanding request.
    @(negedge clk);
    exp_addr.push_back(16'h0401);
    ack_delay = 3;
    run = 1'b1;
    wait_req();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #3;
    check("midrst_req", mem_bus.mem_rd_req, 1'b0);
    check("midrst_valid", ir_valid, 1'b0);
    check("midrst_addr", mem_bus.mem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("midrst_idle_req", mem_bus.mem_rd_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives: error after 8 request cycles, stuck until reset.
    @(negedge clk);
    exp_addr.push_back(16'h0010);
    never_ack = 1'b1;
    run = 1'b1;
    begin
      int unsigned n = 0;
      while (fetch_err !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    #3;
    check("to_fetch_err", fetch_err, 1'b1);
    check("to_req_low", mem_bus.mem_rd_req, 1'b0);
    check("to_req_len", last_req_len, 8);
    repeat (5) @(negedge clk);
    #3;
    check("to_stuck_err", fetch_err, 1'b1);
    check("to_stuck_req", mem_bus.mem_rd_req, 1'b0);
    check("to_stuck_pe", pc_enable, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    never_ack = 1'b0;
    #3;
    check("to_rst_clears_err", fetch_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
`endif

    check("sb_addr_empty", exp_addr.size(), 0);
    check("sb_ir_empty", exp_ir.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
